// File: rtl/cnt_ext_snapshot_pkg.sv
`default_nettype none
// ============================================================================
// Package   : cnt_pkg
// Purpose   : Shared defaults and snapshot FSM state type for the count extender.
// Revision  : 1.0
// ============================================================================
package cnt_pkg;

    localparam int c_DEFAULT_N = 17;
    localparam int c_DEFAULT_M = 15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/cnt_ext_hi.sv
`default_nettype none
// ============================================================================
// Module    : cnt_ext_hi
// Purpose   : M-bit high-order extension register, incremented by an upstream carry.
// Revision  : 1.0
// ============================================================================
module cnt_ext_hi
    import cnt_pkg::*;
#(
    parameter int M = c_DEFAULT_M
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         inc,
    output logic [M-1:0] hi_cnt,
    output logic [M-1:0] hi_eff,
    output logic         wrap
);

    logic [M-1:0] r_hi;

    // hi_eff is the value the register takes at the next edge, so a snapshot
    // built from it is coherent with the post-carry low count.
    assign hi_eff = r_hi + M'(inc);
    assign wrap   = inc & (&r_hi);
    assign hi_cnt = r_hi;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_hi <= '0;
        end else begin
            r_hi <= hi_eff;
        end
    end

endmodule : cnt_ext_hi
`default_nettype wire

// File: rtl/cnt_ext_snapshot.sv
`default_nettype none
// ============================================================================
// Module    : cnt_ext_snapshot
// Purpose   : Extends an upstream counter and serves coherent {hi,lo} snapshots.
// Revision  : 1.0
// ============================================================================
module cnt_ext_snapshot
    import cnt_pkg::*;
#(
    parameter int N = c_DEFAULT_N,
    parameter int M = c_DEFAULT_M
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [N-1:0]   lo_cnt,
    input  logic           lo_cout,
    input  logic           snap_req,
    output logic           snap_valid,
    input  logic           snap_ready,
    output logic [N+M-1:0] snap_data,
    output logic [M-1:0]   hi_cnt,
    output logic           hi_wrap,
    output logic           snap_ovf,
    output logic           proto_err,
    input  logic           flag_clr
);

    logic [M-1:0]   w_hi_eff;
    logic           w_wrap;
    logic           w_capture;
    logic           w_drop;
    logic           w_proto;
    snap_state_t    r_state;
    snap_state_t    w_state_nxt;
    logic [N+M-1:0] r_snap;
    logic           r_hi_wrap;
    logic           r_snap_ovf;
    logic           r_proto_err;

    cnt_ext_hi #(
        .M      (M)
    ) u_hi (
        .clk    (clk),
        .nreset (nreset),
        .inc    (lo_cout),
        .hi_cnt (hi_cnt),
        .hi_eff (w_hi_eff),
        .wrap   (w_wrap)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (snap_ready) begin
                    // Accepting and re-requesting in one cycle recaptures with no bubble.
                    if (snap_req) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (snap_req) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= {w_hi_eff, lo_cnt};
        end
    end

    // Upstream carry is trusted for counting even when flagged as inconsistent.
    assign w_proto = lo_cout && (lo_cnt != '0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_hi_wrap   <= 1'b0;
            r_snap_ovf  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_hi_wrap   <= w_wrap  | (r_hi_wrap   & ~flag_clr);
            r_snap_ovf  <= w_drop  | (r_snap_ovf  & ~flag_clr);
            r_proto_err <= w_proto | (r_proto_err & ~flag_clr);
        end
    end

    assign snap_valid = (r_state == HOLD);
    assign snap_data  = r_snap;
    assign hi_wrap    = r_hi_wrap;
    assign snap_ovf   = r_snap_ovf;
    assign proto_err  = r_proto_err;

endmodule : cnt_ext_snapshot
`default_nettype wire

// File: tb/tb_cnt_ext_snapshot.sv
`default_nettype none
// ============================================================================
// Module    : tb_cnt_ext_snapshot
// Purpose   : Self-checking bench for cnt_ext_snapshot (N=4, M=4) behind a free-running upstream counter.
// Revision  : 1.0
// ============================================================================
module tb_cnt_ext_snapshot;

    localparam int N = 4;
    localparam int M = 4;

    logic         clk;
    logic         nreset;
    logic [N-1:0] lo_cnt;
    logic         lo_cout;
    logic         up_cout;
    logic         force_cout;
    logic         snap_req;
    logic         snap_valid;
    logic         snap_ready;
    logic [N+M-1:0] snap_data;
    logic [M-1:0] hi_cnt;
    logic         hi_wrap;
    logic         snap_ovf;
    logic         proto_err;
    logic         flag_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic         m_valid;
    logic [M-1:0] m_hi;
    logic         m_wrap;
    logic         m_ovf;
    logic         m_perr;
    logic [N+M-1:0] sb[$];

    typedef struct {
        logic req;
        logic rdy;
        logic clr;
        logic exp_valid;
        logic exp_ovf;
    } vec_t;

    vec_t tbl[11];

    cnt_ext_snapshot #(
        .N          (N),
        .M          (M)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .lo_cnt     (lo_cnt),
        .lo_cout    (lo_cout),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (snap_data),
        .hi_cnt     (hi_cnt),
        .hi_wrap    (hi_wrap),
        .snap_ovf   (snap_ovf),
        .proto_err  (proto_err),
        .flag_clr   (flag_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream counter with cin=1: carry pulse coincides with the wrap to 0.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lo_cnt  <= '0;
            up_cout <= 1'b0;
        end else begin
            lo_cnt  <= lo_cnt + 1'b1;
            up_cout <= (lo_cnt == 4'hF);
        end
    end

    assign lo_cout = up_cout | force_cout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("snap_valid", {31'd0, snap_valid}, {31'd0, m_valid});
        chk("hi_cnt", {28'd0, hi_cnt}, {28'd0, m_hi});
        chk("hi_wrap", {31'd0, hi_wrap}, {31'd0, m_wrap});
        chk("snap_ovf", {31'd0, snap_ovf}, {31'd0, m_ovf});
        chk("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
        if (m_valid && sb.size() > 0)
            chk("snap_hold", {24'd0, snap_data}, {24'd0, sb[0]});
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_hi    = '0;
        m_wrap  = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic cycle(input logic req, input logic rdy, input logic clr, input logic frc);
        logic hs, cap, ovf_s, wrap_s, perr_s;
        logic [N+M-1:0] d;
        check_state();
        snap_req   = req;
        snap_ready = rdy;
        flag_clr   = clr;
        force_cout = frc;
        #1;
        hs = m_valid && rdy;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                d = sb.pop_front();
                chk("sb_handshake", {24'd0, snap_data}, {24'd0, d});
            end
        end
        cap    = req && (!m_valid || rdy);
        ovf_s  = req && m_valid && !rdy;
        wrap_s = lo_cout && (m_hi == 4'hF);
        perr_s = lo_cout && (lo_cnt != 4'h0);
        if (cap) sb.push_back({4'(m_hi + {3'd0, lo_cout}), lo_cnt});
        m_wrap  = wrap_s | (m_wrap & ~clr);
        m_ovf   = ovf_s  | (m_ovf  & ~clr);
        m_perr  = perr_s | (m_perr & ~clr);
        m_valid = cap ? 1'b1 : (hs ? 1'b0 : m_valid);
        m_hi    = m_hi + {3'd0, lo_cout};
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [M-1:0] h0;
        bit found;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        nreset     = 1'b0;
        snap_req   = 1'b0;
        snap_ready = 1'b0;
        flag_clr   = 1'b0;
        force_cout = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_valid", {31'd0, snap_valid}, 32'd0);
        chk("rst_data", {24'd0, snap_data}, 32'd0);
        chk("rst_hi", {28'd0, hi_cnt}, 32'd0);
        chk("rst_flags", {29'd0, hi_wrap, snap_ovf, proto_err}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        // T2: request on the cycle the carry lands with hi_cnt=2
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (lo_cnt == 4'h0 && lo_cout && m_hi == 4'h2) found = 1;
            else cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t2_reach", {31'd0, found}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_coherent", {24'd0, snap_data}, 32'h30);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // T3/T4: handshake and overrun vectors
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].req, tbl[i].rdy, tbl[i].clr, 1'b0);
            chk($sformatf("tbl%0d_valid", i), {31'd0, snap_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_ovf", i), {31'd0, snap_ovf}, {31'd0, tbl[i].exp_ovf});
        end

        // T5: extension wrap, snapshot on the wrapping carry
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (lo_cnt == 4'h0 && lo_cout && m_hi == 4'hF) found = 1;
            else cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t5_reach", {31'd0, found}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_hi", {28'd0, hi_cnt}, 32'd0);
        chk("t5_wrap", {31'd0, hi_wrap}, 32'd1);
        chk("t5_data", {24'd0, snap_data}, 32'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // T6: forced carry with nonzero low count
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (lo_cnt == 4'h5) found = 1;
            else cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t6_reach", {31'd0, found}, 32'd1);
        h0 = hi_cnt;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_perr", {31'd0, proto_err}, 32'd1);
        chk("t6_hi_inc", {28'd0, hi_cnt}, {28'd0, 4'(h0 + 4'd1)});

        // T1: asynchronous reset while a snapshot is pending
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_pre_valid", {31'd0, snap_valid}, 32'd1);
        chk("t1_pre_ovf", {31'd0, snap_ovf}, 32'd1);
        #2;
        nreset   = 1'b0;
        snap_req = 1'b0;
        #1;
        chk("t1_valid", {31'd0, snap_valid}, 32'd0);
        chk("t1_hi", {28'd0, hi_cnt}, 32'd0);
        chk("t1_flags", {29'd0, hi_wrap, snap_ovf, proto_err}, 32'd0);
        chk("t1_data", {24'd0, snap_data}, 32'd0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_resume", {28'd0, hi_cnt}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cnt_ext_snapshot
`default_nettype wire
